gcd_lcm_engine: RTL and testbench

Parametrised, handshaked GCD/LCM calculator. It accepts unsigned operand pairs over a valid/ready input port and computes the GCD with the binary (Stein) algorithm, one reduction step per cycle. The LCM is computed as (A/GCD)·B using a sequential restoring divider and a single-cycle multiply. Both results are held on a valid/ready output port with full backpressure. It sits in the arithmetic utility layer as the successor to the fixed-width, no-backpressure GCD/LCM block.

---
 rtl/gcd_lcm_engine.sv | 170 +++++++++++++++++
 tb/tb_gcd_lcm_engine.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_lcm_engine.sv
`default_nettype none
// ============================================================================
//  Module      : gcd_lcm_engine
//  Description : Handshaked GCD/LCM calculator. The GCD uses the binary
//                (Stein) algorithm, one reduction step per cycle. The LCM is
//                (A/GCD)*B, using a restoring divider and a one-cycle
//                multiply. Results are held under full output backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module gcd_lcm_engine #(
    parameter int DATA_W = 8,
    parameter int K_W    = $clog2(DATA_W) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     a_in,
    input  logic [DATA_W-1:0]     b_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     gcd_out,
    output logic [2*DATA_W-1:0]   lcm_out
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STRIP  = 3'd1,
        S_REDUCE = 3'd2,
        S_DIV    = 3'd3,
        S_MUL    = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [K_W-1:0] C_DIV_LAST = K_W'(DATA_W - 1);
    localparam logic [K_W-1:0] C_ONE      = K_W'(1);

    state_t              r_state;
    state_t              w_state_nx;

    // Working operands, captured operands, GCD, divider state
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_a_cap;
    logic [DATA_W-1:0]   r_b_cap;
    logic [DATA_W-1:0]   r_g;
    logic [DATA_W-1:0]   r_quo;
    logic [DATA_W-1:0]   r_rem;
    logic [K_W-1:0]      r_k;
    logic [K_W-1:0]      r_cnt;

    logic                w_zero_op;
    logic                w_any_odd;
    logic [DATA_W-1:0]   w_a_sub;
    logic [DATA_W-1:0]   w_b_sub;
    logic [DATA_W:0]     w_rem_sh;
    logic [DATA_W:0]     w_trial;
    logic                w_fits;
    logic [2*DATA_W-1:0] w_prod;

    assign w_zero_op = (a_in == '0) || (b_in == '0);
    assign w_any_odd = r_a[0] | r_b[0];
    assign w_a_sub   = r_a - r_b;
    assign w_b_sub   = r_b - r_a;

    // Restoring step: shift next dividend bit into the remainder and try g.
    // The remainder is always below g, so the trial result's MSB is a clean
    // borrow flag.
    assign w_rem_sh  = {r_rem, r_quo[DATA_W-1]};
    assign w_trial   = w_rem_sh - {1'b0, r_g};
    assign w_fits    = ~w_trial[DATA_W];

    assign w_prod    = {{DATA_W{1'b0}}, r_quo} * {{DATA_W{1'b0}}, r_b_cap};

    // Next-state decode
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:   if (in_valid) w_state_nx = w_zero_op ? S_DONE : S_STRIP;
            S_STRIP:  if (w_any_odd) w_state_nx = S_REDUCE;
            S_REDUCE: if (r_a == r_b) w_state_nx = S_DIV;
            S_DIV:    if (r_cnt == C_DIV_LAST) w_state_nx = S_MUL;
            S_MUL:    w_state_nx = S_DONE;
            S_DONE:   if (out_ready) w_state_nx = S_IDLE;
            default:  w_state_nx = S_IDLE;
        endcase
    end

    // State register with handshake flags registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            in_ready  <= (w_state_nx == S_IDLE);
            out_valid <= (w_state_nx == S_DONE);
        end
    end

    // Datapath: capture, Stein reduction, division, multiply, result hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_a_cap <= '0;
            r_b_cap <= '0;
            r_g     <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_k     <= '0;
            r_cnt   <= '0;
            gcd_out <= '0;
            lcm_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a_in;
                        r_b     <= b_in;
                        r_a_cap <= a_in;
                        r_b_cap <= b_in;
                        r_k     <= '0;
                        if (w_zero_op) begin
                            gcd_out <= a_in | b_in;
                            lcm_out <= '0;
                        end
                    end
                end
                S_STRIP: begin
                    if (!w_any_odd) begin
                        r_a <= r_a >> 1;
                        r_b <= r_b >> 1;
                        r_k <= r_k + C_ONE;
                    end
                end
                S_REDUCE: begin
                    if (r_a == r_b) begin
                        r_g   <= r_a << r_k;
                        r_quo <= r_a_cap;
                        r_rem <= '0;
                        r_cnt <= '0;
                    end else if (!r_a[0]) begin
                        r_a <= r_a >> 1;
                    end else if (!r_b[0]) begin
                        r_b <= r_b >> 1;
                    end else if (r_a > r_b) begin
                        r_a <= w_a_sub >> 1;
                    end else begin
                        r_b <= w_b_sub >> 1;
                    end
                end
                S_DIV: begin
                    r_rem <= w_fits ? w_trial[DATA_W-1:0] : w_rem_sh[DATA_W-1:0];
                    r_quo <= {r_quo[DATA_W-2:0], w_fits};
                    r_cnt <= r_cnt + C_ONE;
                end
                S_MUL: begin
                    gcd_out <= r_g;
                    lcm_out <= w_prod;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gcd_lcm_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gcd_lcm_engine
//  Description : Directed bench for gcd_lcm_engine at DATA_W=8, 16 and 4,
//                including a full DATA_W=4 sweep against a Euclid model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gcd_lcm_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  a8, b8, gcd8;
    logic [15:0] lcm8;

    logic        in_valid16, in_ready16, out_valid16, out_ready16;
    logic [15:0] a16, b16, gcd16;
    logic [31:0] lcm16;

    logic        in_valid4, in_ready4, out_valid4, out_ready4;
    logic [3:0]  a4, b4, gcd4;
    logic [7:0]  lcm4;

    int checks   = 0;
    int failures = 0;

    gcd_lcm_engine #(.DATA_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8), .a_in(a8), .b_in(b8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .gcd_out(gcd8), .lcm_out(lcm8)
    );

    gcd_lcm_engine #(.DATA_W(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid16), .in_ready(in_ready16), .a_in(a16), .b_in(b16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .gcd_out(gcd16), .lcm_out(lcm16)
    );

    gcd_lcm_engine #(.DATA_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4), .a_in(a4), .b_in(b4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .gcd_out(gcd4), .lcm_out(lcm4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int gcd_ref(input int x, input int y);
        int t;
        while (y != 0) begin
            t = y;
            y = x % y;
            x = t;
        end
        return x;
    endfunction

    // Submit one pair to the 8-bit engine; lat counts edges from the
    // acceptance edge (inclusive) to the first edge after which out_valid is high.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        a8 = a; b8 = b; in_valid8 = 1'b1;
        while (!in_ready8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        lat = 1;
        while (!out_valid8 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release8();
        @(negedge clk);
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
    endtask

    initial begin
        int   lat;
        logic seen;
        logic done, got, unstable4;
        int   n, timeouts, ge, le;
        logic [3:0] g_seen;
        logic [7:0] l_seen;

        rst_n = 1'b0;
        in_valid8 = 0; out_ready8 = 0; a8 = 0; b8 = 0;
        in_valid16 = 0; out_ready16 = 0; a16 = 0; b16 = 0;
        in_valid4 = 0; out_ready4 = 0; a4 = 0; b4 = 0;
        repeat (2) @(negedge clk);

        check("rst_in_ready",  in_ready8, 1);
        check("rst_out_valid", out_valid8, 0);
        check("rst_gcd",       gcd8, 0);
        check("rst_lcm",       lcm8, 0);
        rst_n = 1'b1;

        run8(8'd12, 8'd18, lat);
        check("lat_12_18", lat, 15);
        check("gcd_12_18", gcd8, 6);
        check("lcm_12_18", lcm8, 36);
        release8();
        check("post_xfer_in_ready",  in_ready8, 1);
        check("post_xfer_out_valid", out_valid8, 0);

        run8(8'd255, 8'd254, lat);
        check("lat_255_254_le36", 32'(lat <= 36), 1);
        check("gcd_255_254", gcd8, 1);
        check("lcm_255_254", lcm8, 64770);
        release8();

        run8(8'd0, 8'd7, lat);
        check("lat_0_7", lat, 1);
        check("gcd_0_7", gcd8, 7);
        check("lcm_0_7", lcm8, 0);
        release8();

        run8(8'd0, 8'd0, lat);
        check("lat_0_0", lat, 1);
        check("gcd_0_0", gcd8, 0);
        check("lcm_0_0", lcm8, 0);
        release8();

        // Backpressure: hold DONE for 5 cycles, offer a new pair meanwhile
        run8(8'd9, 8'd6, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) begin
                a8 = 8'd5; b8 = 8'd10; in_valid8 = 1'b1;
            end
            check("bp_out_valid", out_valid8, 1);
            check("bp_gcd",       gcd8, 3);
            check("bp_lcm",       lcm8, 18);
            check("bp_in_ready",  in_ready8, 0);
        end
        in_valid8 = 1'b0;
        release8();
        check("bp_after_in_ready",  in_ready8, 1);
        check("bp_after_out_valid", out_valid8, 0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid8) seen = 1'b1;
        end
        check("bp_no_ghost_job", seen, 0);

        // Reset in the middle of REDUCE
        @(negedge clk);
        a8 = 8'd200; b8 = 8'd150; in_valid8 = 1'b1;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid8, 0);
        check("abort_in_ready",  in_ready8, 1);
        check("abort_gcd",       gcd8, 0);
        check("abort_lcm",       lcm8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run8(8'd8, 8'd12, lat);
        check("lat_8_12", lat, 16);
        check("gcd_8_12", gcd8, 4);
        check("lcm_8_12", lcm8, 24);
        release8();

        // DATA_W=16, equal operands
        @(negedge clk);
        a16 = 16'd40000; b16 = 16'd40000; in_valid16 = 1'b1;
        @(posedge clk);
        #1;
        in_valid16 = 1'b0;
        lat = 1;
        while (!out_valid16 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("lat16_40000", lat, 26);
        check("gcd16_40000", gcd16, 40000);
        check("lcm16_40000", lcm16, 40000);
        @(negedge clk);
        out_ready16 = 1'b1;
        @(negedge clk);
        out_ready16 = 1'b0;

        // DATA_W=4 sweep with random out_ready
        unstable4 = 1'b0;
        timeouts  = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                @(negedge clk);
                a4 = 4'(a); b4 = 4'(b); in_valid4 = 1'b1;
                @(negedge clk);
                in_valid4 = 1'b0;
                got = 1'b0; done = 1'b0; n = 0;
                g_seen = '0; l_seen = '0;
                while (!done && n < 100) begin
                    if (out_valid4) begin
                        if (!got) begin
                            got = 1'b1; g_seen = gcd4; l_seen = lcm4;
                        end else if (gcd4 !== g_seen || lcm4 !== l_seen) begin
                            unstable4 = 1'b1;
                        end
                    end
                    out_ready4 = 1'($urandom_range(0, 1));
                    if (out_valid4 && out_ready4) done = 1'b1;
                    @(negedge clk);
                    n++;
                end
                out_ready4 = 1'b0;
                if (!done) timeouts++;
                ge = gcd_ref(a, b);
                le = (a == 0 || b == 0) ? 0 : (a * b) / ge;
                check($sformatf("sweep_%0d_%0d", a, b), {20'd0, g_seen, l_seen},
                      {20'd0, 4'(ge), 8'(le)});
            end
        end
        check("sweep_stable",   unstable4, 0);
        check("sweep_timeouts", timeouts, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
